// File: rtl/axi_rd_line_fill_if.sv
// Bus bundle between the line-fill sequencer, the cache miss handler (fill_*)
// and the AXI shim read channel (rd_*).
interface axi_rd_line_fill_if #(
    parameter int unsigned AxiNumWords = 4,
    parameter int unsigned AxiIdWidth  = 4
);
    localparam int unsigned BlenWidth = $clog2(AxiNumWords);

    logic                        fill_req_i;
    logic                        fill_gnt_o;
    logic [63:0]                 fill_addr_i;
    logic                        fill_single_i;
    logic [1:0]                  fill_size_i;
    logic [AxiIdWidth-1:0]       fill_id_i;
    logic                        fill_lock_i;
    logic                        fill_valid_o;
    logic                        fill_ready_i;
    logic [AxiNumWords*64-1:0]   fill_data_o;
    logic                        fill_exokay_o;

    logic                        rd_req_o;
    logic                        rd_gnt_i;
    logic [63:0]                 rd_addr_o;
    logic [BlenWidth-1:0]        rd_blen_o;
    logic [1:0]                  rd_size_o;
    logic [AxiIdWidth-1:0]       rd_id_o;
    logic                        rd_lock_o;
    logic                        rd_rdy_o;
    logic                        rd_valid_i;
    logic                        rd_last_i;
    logic [63:0]                 rd_data_i;
    logic [AxiIdWidth-1:0]       rd_id_i;
    logic                        rd_exokay_i;

    // The sequencer itself.
    modport slave (
        input  fill_req_i, fill_addr_i, fill_single_i, fill_size_i, fill_id_i,
               fill_lock_i, fill_ready_i,
               rd_gnt_i, rd_valid_i, rd_last_i, rd_data_i, rd_id_i, rd_exokay_i,
        output fill_gnt_o, fill_valid_o, fill_data_o, fill_exokay_o,
               rd_req_o, rd_addr_o, rd_blen_o, rd_size_o, rd_id_o, rd_lock_o,
               rd_rdy_o
    );

    // The surrounding system: miss handler plus AXI shim.
    modport master (
        output fill_req_i, fill_addr_i, fill_single_i, fill_size_i, fill_id_i,
               fill_lock_i, fill_ready_i,
               rd_gnt_i, rd_valid_i, rd_last_i, rd_data_i, rd_id_i, rd_exokay_i,
        input  fill_gnt_o, fill_valid_o, fill_data_o, fill_exokay_o,
               rd_req_o, rd_addr_o, rd_blen_o, rd_size_o, rd_id_o, rd_lock_o,
               rd_rdy_o
    );
endinterface

// File: rtl/axi_rd_line_fill.sv
// Read-side line-fill sequencer: one outstanding line or single-dword read,
// beats assembled into a line buffer with an aggregated EXOKAY flag.
module axi_rd_line_fill #(
    parameter int unsigned AxiNumWords = 4,
    parameter int unsigned AxiIdWidth  = 4
) (
    input logic              clk_i,
    input logic              rst_ni,
    axi_rd_line_fill_if.slave bus
);
    localparam int unsigned IdxWidth = $clog2(AxiNumWords);
    localparam int unsigned LineBits = IdxWidth + 3;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(AxiNumWords - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

    state_e                          state_q, state_d;
    logic [63:0]                     addr_q;
    logic                            single_q;
    logic [1:0]                      size_q;
    logic [AxiIdWidth-1:0]           id_q;
    logic                            lock_q;
    logic [AxiNumWords-1:0][63:0]    line_q;
    logic [IdxWidth-1:0]             cnt_q;
    logic                            exokay_q;
    logic                            beat_ok;
    logic [IdxWidth-1:0]             beat_idx;

    // Foreign-ID beats still see rd_rdy_o, so they are consumed but ignored here.
    assign beat_ok  = (state_q == RESP) && bus.rd_valid_i && (bus.rd_id_i == id_q);
    assign beat_idx = single_q ? addr_q[LineBits-1:3] : cnt_q;

    assign bus.fill_data_o   = line_q;
    assign bus.fill_exokay_o = exokay_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.fill_gnt_o   = 1'b0;
        bus.fill_valid_o = 1'b0;
        bus.rd_req_o     = 1'b0;
        bus.rd_rdy_o     = 1'b0;
        bus.rd_addr_o    = '0;
        bus.rd_blen_o    = '0;
        bus.rd_size_o    = '0;
        bus.rd_id_o      = '0;
        bus.rd_lock_o    = 1'b0;
        case (state_q)
            IDLE: begin
                bus.fill_gnt_o = bus.fill_req_i;
                if (bus.fill_req_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                bus.rd_req_o  = 1'b1;
                bus.rd_addr_o = single_q ? addr_q : {addr_q[63:LineBits], {LineBits{1'b0}}};
                bus.rd_blen_o = single_q ? '0 : LastIdx;
                bus.rd_size_o = single_q ? size_q : 2'd3;
                bus.rd_id_o   = id_q;
                bus.rd_lock_o = lock_q;
                if (bus.rd_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.rd_rdy_o = 1'b1;
                if (beat_ok && bus.rd_last_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.fill_valid_o = 1'b1;
                if (bus.fill_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture and beat assembly; the buffer only clears once the shim grants.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            single_q <= 1'b0;
            size_q   <= '0;
            id_q     <= '0;
            lock_q   <= 1'b0;
            line_q   <= '0;
            cnt_q    <= '0;
            exokay_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.fill_req_i) begin
                        addr_q   <= bus.fill_addr_i;
                        single_q <= bus.fill_single_i;
                        size_q   <= bus.fill_size_i;
                        id_q     <= bus.fill_id_i;
                        lock_q   <= bus.fill_lock_i;
                    end
                end
                REQ: begin
                    if (bus.rd_gnt_i) begin
                        line_q   <= '0;
                        cnt_q    <= '0;
                        exokay_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (beat_ok) begin
                        line_q[beat_idx] <= bus.rd_data_i;
                        exokay_q         <= exokay_q & bus.rd_exokay_i;
                        if (!single_q && (cnt_q != LastIdx)) begin
                            cnt_q <= cnt_q + IdxWidth'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_line_fill.sv
// Directed scoreboard bench for axi_rd_line_fill: expected lines are queued when
// the beats are driven and popped when the sequencer presents its result.
module tb_axi_rd_line_fill;
    localparam int unsigned NW = 4;
    localparam int unsigned IW = 4;
    localparam int unsigned DW = NW * 64;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    axi_rd_line_fill_if #(.AxiNumWords(NW), .AxiIdWidth(IW)) bus ();

    axi_rd_line_fill #(.AxiNumWords(NW), .AxiIdWidth(IW)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          exokay;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [DW-1:0] pack4(input logic [63:0] d0, input logic [63:0] d1,
                                            input logic [63:0] d2, input logic [63:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        bus.fill_req_i    = 1'b0;
        bus.fill_addr_i   = '0;
        bus.fill_single_i = 1'b0;
        bus.fill_size_i   = '0;
        bus.fill_id_i     = '0;
        bus.fill_lock_i   = 1'b0;
        bus.fill_ready_i  = 1'b0;
        bus.rd_gnt_i      = 1'b0;
        bus.rd_valid_i    = 1'b0;
        bus.rd_last_i     = 1'b0;
        bus.rd_data_i     = '0;
        bus.rd_id_i       = '0;
        bus.rd_exokay_i   = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rd_req"},   DW'(bus.rd_req_o),      '0);
        checkOutput({tag, "_rd_rdy"},   DW'(bus.rd_rdy_o),      '0);
        checkOutput({tag, "_valid"},    DW'(bus.fill_valid_o),  '0);
        checkOutput({tag, "_data"},     bus.fill_data_o,        '0);
        checkOutput({tag, "_exokay"},   DW'(bus.fill_exokay_o), '0);
        checkOutput({tag, "_rd_addr"},  DW'(bus.rd_addr_o),     '0);
        checkOutput({tag, "_rd_blen"},  DW'(bus.rd_blen_o),     '0);
        checkOutput({tag, "_rd_size"},  DW'(bus.rd_size_o),     '0);
        checkOutput({tag, "_rd_id"},    DW'(bus.rd_id_o),       '0);
        checkOutput({tag, "_rd_lock"},  DW'(bus.rd_lock_o),     '0);
        checkOutput({tag, "_gnt"},      DW'(bus.fill_gnt_o),    '0);
    endtask

    // Presents a fill (unless already granted), checks the shim request, stalls, then grants.
    task automatic applyStimulus(input logic [63:0] addr, input logic single, input logic [1:0] size,
                                 input logic [IW-1:0] id, input logic lock, input bit presented,
                                 input int stall, input logic [63:0] exp_addr,
                                 input logic [1:0] exp_blen, input logic [1:0] exp_size);
        if (!presented) begin
            @(negedge clk_i);
            bus.fill_addr_i   = addr;
            bus.fill_single_i = single;
            bus.fill_size_i   = size;
            bus.fill_id_i     = id;
            bus.fill_lock_i   = lock;
            bus.fill_req_i    = 1'b1;
            #1;
            checkOutput("fill_gnt_idle", DW'(bus.fill_gnt_o), DW'(1'b1));
        end
        @(negedge clk_i);
        bus.fill_req_i = (stall > 0);
        #1;
        checkOutput("rd_req",  DW'(bus.rd_req_o),  DW'(1'b1));
        checkOutput("rd_addr", DW'(bus.rd_addr_o), DW'(exp_addr));
        checkOutput("rd_blen", DW'(bus.rd_blen_o), DW'(exp_blen));
        checkOutput("rd_size", DW'(bus.rd_size_o), DW'(exp_size));
        checkOutput("rd_id",   DW'(bus.rd_id_o),   DW'(bus.fill_id_i));
        checkOutput("rd_lock", DW'(bus.rd_lock_o), DW'(bus.fill_lock_i));
        checkOutput("gnt_busy_req", DW'(bus.fill_gnt_o), '0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk_i);
            #1;
            checkOutput("stall_rd_req",  DW'(bus.rd_req_o),   DW'(1'b1));
            checkOutput("stall_rd_addr", DW'(bus.rd_addr_o),  DW'(exp_addr));
            checkOutput("stall_rd_blen", DW'(bus.rd_blen_o),  DW'(exp_blen));
            checkOutput("stall_rdy",     DW'(bus.rd_rdy_o),   '0);
            checkOutput("stall_gnt",     DW'(bus.fill_gnt_o), '0);
        end
        bus.fill_req_i = 1'b0;
        bus.rd_gnt_i   = 1'b1;
    endtask

    task automatic driveBeat(input logic [63:0] d, input logic [IW-1:0] id, input logic ex,
                             input logic last);
        @(negedge clk_i);
        bus.rd_gnt_i    = 1'b0;
        bus.rd_valid_i  = 1'b1;
        bus.rd_data_i   = d;
        bus.rd_id_i     = id;
        bus.rd_exokay_i = ex;
        bus.rd_last_i   = last;
        #1;
        checkOutput("beat_rdy",   DW'(bus.rd_rdy_o),     DW'(1'b1));
        checkOutput("beat_valid", DW'(bus.fill_valid_o), '0);
    endtask

    task automatic gapBeat();
        @(negedge clk_i);
        bus.rd_gnt_i   = 1'b0;
        bus.rd_valid_i = 1'b0;
        bus.rd_last_i  = 1'b0;
    endtask

    // Expects the result one cycle after the last beat, holds it for 'hold' cycles, then takes it.
    task automatic collectResult(input int hold, input logic next_req);
        exp_t e;
        @(negedge clk_i);
        bus.rd_valid_i = 1'b0;
        bus.rd_last_i  = 1'b0;
        #1;
        checkOutput("fill_valid_lat", DW'(bus.fill_valid_o), DW'(1'b1));
        e = sb.pop_front();
        checkOutput("fill_data",   bus.fill_data_o,        e.data);
        checkOutput("fill_exokay", DW'(bus.fill_exokay_o), DW'(e.exokay));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            #1;
            checkOutput("hold_valid", DW'(bus.fill_valid_o), DW'(1'b1));
            checkOutput("hold_data",  bus.fill_data_o,       e.data);
            checkOutput("hold_gnt",   DW'(bus.fill_gnt_o),   '0);
        end
        bus.fill_ready_i = 1'b1;
        #1;
        checkOutput("handshake_gnt", DW'(bus.fill_gnt_o), '0);
        @(negedge clk_i);
        bus.fill_ready_i = 1'b0;
        #1;
        checkOutput("after_valid", DW'(bus.fill_valid_o), '0);
        checkOutput("after_gnt",   DW'(bus.fill_gnt_o),   DW'(next_req));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] b [4];
        idleInputs();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checkAllZero("reset");
        rst_ni = 1'b1;

        // Line fill without stalls.
        applyStimulus(64'h8000_0038, 1'b0, 2'd0, 4'd1, 1'b0, 1'b0, 0, 64'h8000_0020, 2'd3, 2'd3);
        sb.push_back('{pack4(64'hA0, 64'hA1, 64'hA2, 64'hA3), 1'b1});
        driveBeat(64'hA0, 4'd1, 1'b1, 1'b0);
        driveBeat(64'hA1, 4'd1, 1'b1, 1'b0);
        driveBeat(64'hA2, 4'd1, 1'b1, 1'b0);
        driveBeat(64'hA3, 4'd1, 1'b1, 1'b1);
        collectResult(0, 1'b0);

        // Single-dword read lands in slot addr[4:3].
        applyStimulus(64'h1018, 1'b1, 2'd2, 4'd2, 1'b1, 1'b0, 0, 64'h1018, 2'd0, 2'd2);
        sb.push_back('{pack4(64'h0, 64'h0, 64'h0, 64'hDEAD), 1'b0});
        driveBeat(64'hDEAD, 4'd2, 1'b0, 1'b1);
        collectResult(0, 1'b0);

        // Grant withheld for 5 cycles, random gaps between beats.
        for (int k = 0; k < 4; k++) b[k] = 64'hB000_0000 + 64'(k);
        applyStimulus(64'h2000_0108, 1'b0, 2'd1, 4'd3, 1'b0, 1'b0, 5, 64'h2000_0100, 2'd3, 2'd3);
        sb.push_back('{pack4(b[0], b[1], b[2], b[3]), 1'b1});
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 2)) gapBeat();
            driveBeat(b[k], 4'd3, 1'b1, k == 3);
        end
        collectResult(0, 1'b0);

        // Foreign-ID beat (even flagged last) dropped; an OKAY beat clears exokay.
        applyStimulus(64'h0000_0040, 1'b0, 2'd0, 4'd5, 1'b1, 1'b0, 0, 64'h0000_0040, 2'd3, 2'd3);
        sb.push_back('{pack4(64'hC0, 64'hC1, 64'hC2, 64'hC3), 1'b0});
        driveBeat(64'hC0,  4'd5, 1'b1, 1'b0);
        driveBeat(64'hBAD, 4'd6, 1'b0, 1'b1);
        driveBeat(64'hC1,  4'd5, 1'b1, 1'b0);
        driveBeat(64'hC2,  4'd5, 1'b0, 1'b0);
        driveBeat(64'hC3,  4'd5, 1'b1, 1'b1);
        collectResult(0, 1'b0);

        // Backpressure for 3 cycles with the next fill already pending.
        applyStimulus(64'h3000, 1'b0, 2'd0, 4'd7, 1'b0, 1'b0, 0, 64'h3000, 2'd3, 2'd3);
        sb.push_back('{pack4(64'hD0, 64'hD1, 64'hD2, 64'hD3), 1'b1});
        driveBeat(64'hD0, 4'd7, 1'b1, 1'b0);
        driveBeat(64'hD1, 4'd7, 1'b1, 1'b0);
        driveBeat(64'hD2, 4'd7, 1'b1, 1'b0);
        driveBeat(64'hD3, 4'd7, 1'b1, 1'b1);
        bus.fill_addr_i   = 64'h3008;
        bus.fill_single_i = 1'b1;
        bus.fill_size_i   = 2'd3;
        bus.fill_id_i     = 4'd8;
        bus.fill_lock_i   = 1'b0;
        bus.fill_req_i    = 1'b1;
        collectResult(3, 1'b1);
        applyStimulus(64'h3008, 1'b1, 2'd3, 4'd8, 1'b0, 1'b1, 0, 64'h3008, 2'd0, 2'd3);
        sb.push_back('{pack4(64'h0, 64'h5555, 64'h0, 64'h0), 1'b1});
        driveBeat(64'h5555, 4'd8, 1'b1, 1'b1);
        collectResult(0, 1'b0);

        // Reset after two of four beats, then a clean fill.
        applyStimulus(64'h4000, 1'b0, 2'd0, 4'd9, 1'b1, 1'b0, 0, 64'h4000, 2'd3, 2'd3);
        driveBeat(64'hE0, 4'd9, 1'b1, 1'b0);
        driveBeat(64'hE1, 4'd9, 1'b1, 1'b0);
        @(negedge clk_i);
        bus.rd_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(64'h5010, 1'b0, 2'd0, 4'd10, 1'b0, 1'b0, 0, 64'h5000, 2'd3, 2'd3);
        sb.push_back('{pack4(64'hF0, 64'hF1, 64'hF2, 64'hF3), 1'b1});
        driveBeat(64'hF0, 4'd10, 1'b1, 1'b0);
        driveBeat(64'hF1, 4'd10, 1'b1, 1'b0);
        driveBeat(64'hF2, 4'd10, 1'b1, 1'b0);
        driveBeat(64'hF3, 4'd10, 1'b1, 1'b1);
        collectResult(0, 1'b0);

        checkOutput("sb_drained", DW'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
